// File: rtl/demultiplexer_pair_pkg.sv
// Shared types and constants for the two-slot demultiplexer / pair assembler.
package demultiplexer_pkg;

  typedef enum logic [1:0] {
    EMPTY  = 2'd0,
    HAVE_A = 2'd1,
    HAVE_B = 2'd2,
    PAIR   = 2'd3
  } demux_state_t;

  localparam logic SEL_A = 1'b0;
  localparam logic SEL_B = 1'b1;

  // State reached when exactly one slot becomes fresh through a write to slot sel.
  function automatic demux_state_t single_state(input logic sel);
    return (sel == SEL_B) ? HAVE_B : HAVE_A;
  endfunction

endpackage

// File: rtl/demultiplexer_pair_if.sv
// Producer-side write handshake and consumer-side pair handshake.
interface demultiplexer_pair_if #(
  parameter int WIDTH = 8
);

  logic [WIDTH-1:0] in_data;
  logic             in_sel;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] out_a;
  logic [WIDTH-1:0] out_b;
  logic             out_valid;
  logic             out_ready;
  logic             dup_err;

  // Environment side: drives words in and takes pairs out.
  modport master (
    output in_data, in_sel, in_valid, out_ready,
    input  in_ready, out_a, out_b, out_valid, dup_err
  );

  // Block side.
  modport slave (
    input  in_data, in_sel, in_valid, out_ready,
    output in_ready, out_a, out_b, out_valid, dup_err
  );

endinterface

// File: rtl/demultiplexer_pair_slot.sv
// One data slot: load-enabled register, cleared by synchronous reset.
module demux_slot #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // Reset takes priority over a load in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/demultiplexer_pair.sv
// Routes incoming words to slot A or B and presents {a, b} once both are fresh.
//
//   state  | meaning
//   -------+-----------------------------
//   EMPTY  | neither slot is fresh
//   HAVE_A | only A is fresh
//   HAVE_B | only B is fresh
//   PAIR   | both fresh, out_valid high
//
// Slot contents survive a drain; only freshness is tracked by the state.
module demultiplexer_pair
  import demultiplexer_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input logic                 clk,
  input logic                 reset,
  demultiplexer_pair_if.slave bus
);

  demux_state_t state, state_nxt;
  logic         accept;
  logic         drain;
  logic         load_a;
  logic         load_b;
  logic         ready;
  logic         dup_err_q;

  // Only a full pair can stall the producer; it may refill during the drain cycle.
  // In the partial states a write to the already-fresh slot simply overwrites it.
  always_comb begin
    ready = 1'b1;
    if (state == PAIR) begin
      ready = bus.out_ready;
    end
  end

  assign accept        = bus.in_valid && ready;
  assign drain         = (state == PAIR) && bus.out_ready;
  assign load_a        = accept && (bus.in_sel == SEL_A);
  assign load_b        = accept && (bus.in_sel == SEL_B);
  assign bus.in_ready  = ready;
  assign bus.out_valid = (state == PAIR);
  assign bus.dup_err   = dup_err_q;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode from accept/drain.
  always_comb begin
    state_nxt = state;
    unique case (state)
      EMPTY: begin
        if (accept) state_nxt = single_state(bus.in_sel);
      end
      HAVE_A: begin
        if (accept && bus.in_sel == SEL_B) state_nxt = PAIR;
      end
      HAVE_B: begin
        if (accept && bus.in_sel == SEL_A) state_nxt = PAIR;
      end
      PAIR: begin
        if (drain) begin
          state_nxt = accept ? single_state(bus.in_sel) : EMPTY;
        end
      end
      default: state_nxt = EMPTY;
    endcase
  end

  // Sticky flag: producer offered a word while the unread pair blocked it.
  always_ff @(posedge clk) begin
    if (reset) begin
      dup_err_q <= 1'b0;
    end else if (state == PAIR && bus.in_valid && !bus.out_ready) begin
      dup_err_q <= 1'b1;
    end
  end

  demux_slot #(.WIDTH(WIDTH)) u_slot_a (
    .clk   (clk),
    .reset (reset),
    .load  (load_a),
    .d     (bus.in_data),
    .q     (bus.out_a)
  );

  demux_slot #(.WIDTH(WIDTH)) u_slot_b (
    .clk   (clk),
    .reset (reset),
    .load  (load_b),
    .d     (bus.in_data),
    .q     (bus.out_b)
  );

endmodule

// File: tb/tb_demultiplexer_pair.sv
// Directed bench for demultiplexer_pair with a pair scoreboard.
module tb_demultiplexer_pair;
  import demultiplexer_pkg::*;

  logic clk;
  logic reset;
  int   total;
  int   passed;
  int   fails;

  // Reference state kept from the producer/consumer point of view.
  logic       fa, fb;
  logic [7:0] va, vb;
  logic       dup;
  logic [15:0] sb[$];

  demultiplexer_pair_if #(.WIDTH(8)) bus ();

  demultiplexer_pair #(.WIDTH(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock of traffic: check registered outputs, drive, check ready, update model.
  task automatic step(input logic v, input logic s, input logic [7:0] d, input logic r);
    logic [15:0] exp_pair;
    logic        exp_ready;
    @(negedge clk);
    check("out_a", {8'h00, bus.out_a}, {8'h00, va});
    check("out_b", {8'h00, bus.out_b}, {8'h00, vb});
    check("out_valid", {15'd0, bus.out_valid}, {15'd0, fa && fb});
    check("dup_err", {15'd0, bus.dup_err}, {15'd0, dup});
    reset         = 1'b0;
    bus.in_valid  = v;
    bus.in_sel    = s;
    bus.in_data   = d;
    bus.out_ready = r;
    #1;
    exp_ready = !(fa && fb) || r;
    check("in_ready", {15'd0, bus.in_ready}, {15'd0, exp_ready});
    if (fa && fb && r) begin
      if (sb.size() == 0) begin
        check("sb_underflow", 16'd1, 16'd0);
      end else begin
        exp_pair = sb.pop_front();
        check("pair", {bus.out_a, bus.out_b}, exp_pair);
      end
      fa = 1'b0;
      fb = 1'b0;
    end
    if (v && exp_ready) begin
      if (s == SEL_B) begin
        fb = 1'b1;
        vb = d;
      end else begin
        fa = 1'b1;
        va = d;
      end
      if (fa && fb) sb.push_back({va, vb});
    end else if (v && !exp_ready) begin
      dup = 1'b1;
    end
    @(posedge clk);
  endtask

  task automatic do_reset(input logic v, input logic s, input logic [7:0] d, input logic r);
    @(negedge clk);
    reset         = 1'b1;
    bus.in_valid  = v;
    bus.in_sel    = s;
    bus.in_data   = d;
    bus.out_ready = r;
    @(posedge clk);
    fa  = 1'b0;
    fb  = 1'b0;
    va  = 8'h00;
    vb  = 8'h00;
    dup = 1'b0;
    sb.delete();
  endtask

  initial begin
    total = 0;
    passed = 0;
    fails = 0;
    bus.in_valid  = 1'b0;
    bus.in_sel    = 1'b0;
    bus.in_data   = 8'h00;
    bus.out_ready = 1'b0;
    do_reset(1'b0, 1'b0, 8'h00, 1'b0);
    do_reset(1'b0, 1'b0, 8'h00, 1'b0);

    // Idle after reset.
    step(1'b0, 1'b0, 8'h00, 1'b0);
    step(1'b0, 1'b0, 8'h00, 1'b0);

    // Build a pair and hold it with no consumer.
    step(1'b1, SEL_A, 8'h12, 1'b0);
    step(1'b1, SEL_B, 8'h34, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 8'h00, 1'b0);

    // Drain with simultaneous refill into B.
    step(1'b1, SEL_B, 8'h56, 1'b1);
    step(1'b0, 1'b0, 8'h00, 1'b0);

    // Complete and drain that pair to get back to EMPTY.
    step(1'b1, SEL_A, 8'hAB, 1'b0);
    step(1'b0, 1'b0, 8'h00, 1'b1);
    step(1'b0, 1'b0, 8'h00, 1'b0);

    // Overwrite in HAVE_A, then complete.
    step(1'b1, SEL_A, 8'h77, 1'b0);
    step(1'b1, SEL_A, 8'h88, 1'b0);
    step(1'b1, SEL_B, 8'h99, 1'b0);
    step(1'b0, 1'b0, 8'h00, 1'b0);

    // Producer ahead of consumer: refused write, sticky error.
    step(1'b1, SEL_A, 8'hEE, 1'b0);
    step(1'b0, 1'b0, 8'h00, 1'b0);
    step(1'b0, 1'b0, 8'h00, 1'b1);
    step(1'b0, 1'b0, 8'h00, 1'b0);

    // Back-to-back pairs with refill on every drain cycle.
    for (int i = 0; i < 12; i++) begin
      step(1'b1, logic'(i % 2), 8'($urandom_range(0, 255)), 1'b1);
    end
    step(1'b0, 1'b0, 8'h00, 1'b1);
    step(1'b0, 1'b0, 8'h00, 1'b0);

    // Reset in PAIR with consumer ready and a write offered: reset wins.
    step(1'b1, SEL_A, 8'h11, 1'b0);
    step(1'b1, SEL_B, 8'h22, 1'b0);
    do_reset(1'b1, SEL_A, 8'h33, 1'b1);
    step(1'b0, 1'b0, 8'h00, 1'b0);
    step(1'b0, 1'b0, 8'h00, 1'b0);

    check("sb_empty", 16'(sb.size()), 16'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
